// File: rtl/dmem_bus_if_pkg.sv
// Shared definitions for the data-side Wishbone master: FSM states,
// pipeline stall-vector indices and bus widths.
package dmem_bus_if_pkg;

  localparam logic RST_ENABLE = 1'b1;

  localparam int WB_AW   = 32;
  localparam int WB_DW   = 32;
  localparam int WB_SW   = 4;
  localparam int STALL_W = 6;

  typedef enum int {
    STALL_PC  = 0,
    STALL_IF  = 1,
    STALL_ID  = 2,
    STALL_EX  = 3,
    STALL_MEM = 4,
    STALL_WB  = 5
  } stall_idx_e;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_BUSY       = 2'd1,
    ST_WAIT_STALL = 2'd2
  } state_e;

endpackage

// File: rtl/dmem_bus_if_if.sv
// Wishbone B4 classic data bus as seen by the memory-stage master.
interface dmem_bus_if_if;
  import dmem_bus_if_pkg::*;

  logic             wb_cyc_o;
  logic             wb_stb_o;
  logic             wb_we_o;
  logic [WB_AW-1:0] wb_adr_o;
  logic [WB_DW-1:0] wb_dat_o;
  logic [WB_SW-1:0] wb_sel_o;
  logic [WB_DW-1:0] wb_dat_i;
  logic             wb_ack_i;

  modport master (
    output wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o,
    input  wb_dat_i, wb_ack_i
  );

  modport slave (
    input  wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o,
    output wb_dat_i, wb_ack_i
  );
endinterface

// File: rtl/dmem_bus_if.sv
// Turns single-cycle memory-stage requests into registered Wishbone
// transactions, stalling the pipeline while a transaction is in flight.
module dmem_bus_if
  import dmem_bus_if_pkg::*;
#(
  parameter int TIMEOUT_CYC = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STALL_W-1:0] stall_i,
  input  logic               flush_i,
  input  logic               cpu_ce_i,
  input  logic [WB_AW-1:0]   cpu_addr_i,
  input  logic [WB_DW-1:0]   cpu_data_i,
  input  logic               cpu_we_i,
  input  logic [WB_SW-1:0]   cpu_sel_i,
  output logic [WB_DW-1:0]   cpu_data_o,
  output logic               stallreq_o,
  output logic               bus_err_o,
  dmem_bus_if_if.master      wb
);

  state_e           r_state;
  state_e           w_next_state;
  logic [WB_DW-1:0] r_rd_buf;
  logic             r_bus_err;
  logic             w_start;
  logic             w_end;
  logic             w_capture;
  logic             w_abort;
  logic             w_timeout;

  // NOTE: every signal gets a default first so no path through the case infers a latch.
  always_comb begin
    w_next_state = r_state;
    w_start      = 1'b0;
    w_end        = 1'b0;
    w_capture    = 1'b0;
    w_abort      = 1'b0;
    stallreq_o   = 1'b0;
    cpu_data_o   = '0;
    case (r_state)
      ST_IDLE: begin
        stallreq_o = cpu_ce_i & ~flush_i;
        if (cpu_ce_i && !flush_i) begin
          w_start      = 1'b1;
          w_next_state = ST_BUSY;
        end
      end
      ST_BUSY: begin
        stallreq_o = ~wb.wb_ack_i & ~flush_i;
        // A flushed access never hands data to the pipeline, even if acked.
        cpu_data_o = (wb.wb_ack_i && !flush_i) ? wb.wb_dat_i : '0;
        if (flush_i) begin
          w_end        = 1'b1;
          w_next_state = ST_IDLE;
        end else if (wb.wb_ack_i) begin
          w_end        = 1'b1;
          w_capture    = 1'b1;
          w_next_state = (|stall_i) ? ST_WAIT_STALL : ST_IDLE;
        end else if (w_timeout) begin
          w_end        = 1'b1;
          w_abort      = 1'b1;
          w_next_state = ST_IDLE;
        end
      end
      ST_WAIT_STALL: begin
        cpu_data_o = r_rd_buf;
        if (stall_i == '0) w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) r_state <= ST_IDLE;
    else                   r_state <= w_next_state;
  end

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE || w_end) begin
      wb.wb_cyc_o <= 1'b0;
      wb.wb_stb_o <= 1'b0;
      wb.wb_we_o  <= 1'b0;
      wb.wb_adr_o <= '0;
      wb.wb_dat_o <= '0;
      wb.wb_sel_o <= '0;
    end else if (w_start) begin
      wb.wb_cyc_o <= 1'b1;
      wb.wb_stb_o <= 1'b1;
      wb.wb_we_o  <= cpu_we_i;
      wb.wb_adr_o <= cpu_addr_i;
      wb.wb_dat_o <= cpu_data_i;
      wb.wb_sel_o <= cpu_sel_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      r_rd_buf  <= '0;
      r_bus_err <= 1'b0;
    end else begin
      r_bus_err <= w_abort;
      if (w_capture)  r_rd_buf <= wb.wb_dat_i;
      else if (w_end) r_rd_buf <= '0;
    end
  end

  assign bus_err_o = r_bus_err;

  generate
    if (TIMEOUT_CYC > 0) begin : g_wdog
      localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
      logic [CNT_W-1:0] r_wdog_cnt;

      // Counts BUSY cycles; fires on the last cycle of the allowed window.
      always_ff @(posedge clk) begin
        if (rst == RST_ENABLE || w_start) r_wdog_cnt <= '0;
        else if (r_state == ST_BUSY)      r_wdog_cnt <= r_wdog_cnt + 1'b1;
      end

      assign w_timeout = (r_wdog_cnt == CNT_W'(TIMEOUT_CYC - 1));
    end else begin : g_no_wdog
      assign w_timeout = 1'b0;
    end
  endgenerate

endmodule

// File: tb/tb_dmem_bus_if.sv
// Cycle-by-cycle vector bench for dmem_bus_if with a 4-cycle ack watchdog.
module tb_dmem_bus_if;

  logic        clk;
  logic        rst;
  logic [5:0]  stall_i;
  logic        flush_i;
  logic        cpu_ce_i;
  logic [31:0] cpu_addr_i;
  logic [31:0] cpu_data_i;
  logic        cpu_we_i;
  logic [3:0]  cpu_sel_i;
  logic [31:0] cpu_data_o;
  logic        stallreq_o;
  logic        bus_err_o;

  dmem_bus_if_if bus();

  dmem_bus_if #(.TIMEOUT_CYC(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .stall_i    (stall_i),
    .flush_i    (flush_i),
    .cpu_ce_i   (cpu_ce_i),
    .cpu_addr_i (cpu_addr_i),
    .cpu_data_i (cpu_data_i),
    .cpu_we_i   (cpu_we_i),
    .cpu_sel_i  (cpu_sel_i),
    .cpu_data_o (cpu_data_o),
    .stallreq_o (stallreq_o),
    .bus_err_o  (bus_err_o),
    .wb         (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        ce;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdat;
    logic [3:0]  sel;
    logic        flush;
    logic [5:0]  stall;
    logic        ack;
    logic [31:0] rdat;
    logic        x_sreq;
    logic [31:0] x_cd;
    logic        x_cyc;
    logic        x_we;
    logic [31:0] x_adr;
    logic [31:0] x_dat;
    logic [3:0]  x_sel;
    logic        x_err;
  } vec_t;

  vec_t vq[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  function automatic vec_t mk(
    logic r, logic ce, logic we, logic [31:0] addr, logic [31:0] wdat, logic [3:0] sel,
    logic fl, logic [5:0] st, logic ack, logic [31:0] rdat,
    logic xs, logic [31:0] xcd, logic xc, logic xwe, logic [31:0] xadr, logic [31:0] xdat,
    logic [3:0] xsel, logic xerr);
    vec_t v;
    v.rst = r;  v.ce = ce;  v.we = we;  v.addr = addr;  v.wdat = wdat;  v.sel = sel;
    v.flush = fl;  v.stall = st;  v.ack = ack;  v.rdat = rdat;
    v.x_sreq = xs;  v.x_cd = xcd;  v.x_cyc = xc;  v.x_we = xwe;  v.x_adr = xadr;
    v.x_dat = xdat;  v.x_sel = xsel;  v.x_err = xerr;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  task automatic apply(input vec_t v);
    rst        = v.rst;
    cpu_ce_i   = v.ce;
    cpu_we_i   = v.we;
    cpu_addr_i = v.addr;
    cpu_data_i = v.wdat;
    cpu_sel_i  = v.sel;
    flush_i    = v.flush;
    stall_i    = v.stall;
    bus.wb_ack_i = v.ack;
    bus.wb_dat_i = v.rdat;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    int sreq_cycles;

    //         rst ce we addr          wdat          sel      fl st       ack rdat          sreq cd            cyc we adr           dat           sel      err
    vq.push_back(mk(1, 0, 0, 32'h0,        32'h0,        4'h0,    0, 6'h00, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0,   32'h0,        4'h0,    0)); // 0 reset
    vq.push_back(mk(0, 1, 0, 32'h100,      32'h0,        4'hF,    0, 6'h00, 0, 32'h0,        1, 32'h0,        0, 0, 32'h0,   32'h0,        4'h0,    0)); // 1 load request
    vq.push_back(mk(0, 0, 0, 32'h0,        32'h0,        4'h0,    0, 6'h00, 1, 32'hDEADBEEF, 0, 32'hDEADBEEF, 1, 0, 32'h100, 32'h0,        4'hF,    0)); // 2 zero-wait ack
    vq.push_back(mk(0, 0, 0, 32'h0,        32'h0,        4'h0,    0, 6'h00, 0, 32'hDEADBEEF, 0, 32'h0,        0, 0, 32'h0,   32'h0,        4'h0,    0)); // 3 idle
    vq.push_back(mk(0, 1, 1, 32'h204,      32'h5A5A5A5A, 4'b0100, 0, 6'h00, 0, 32'h0,        1, 32'h0,        0, 0, 32'h0,   32'h0,        4'h0,    0)); // 4 store request
    vq.push_back(mk(0, 1, 0, 32'hFFFFFFFC, 32'h11111111, 4'hF,    0, 6'h00, 0, 32'h0,        1, 32'h0,        1, 1, 32'h204, 32'h5A5A5A5A, 4'b0100, 0)); // 5 wait 1, cpu inputs ignored
    vq.push_back(mk(0, 1, 0, 32'hFFFFFFFC, 32'h11111111, 4'hF,    0, 6'h00, 0, 32'h0,        1, 32'h0,        1, 1, 32'h204, 32'h5A5A5A5A, 4'b0100, 0)); // 6 wait 2
    vq.push_back(mk(0, 1, 0, 32'hFFFFFFFC, 32'h11111111, 4'hF,    0, 6'h00, 0, 32'h0,        1, 32'h0,        1, 1, 32'h204, 32'h5A5A5A5A, 4'b0100, 0)); // 7 wait 3
    vq.push_back(mk(0, 0, 0, 32'h0,        32'h0,        4'h0,    0, 6'h00, 1, 32'h12345678, 0, 32'h12345678, 1, 1, 32'h204, 32'h5A5A5A5A, 4'b0100, 0)); // 8 store ack
    vq.push_back(mk(0, 0, 0, 32'h0,        32'h0,        4'h0,    0, 6'h00, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0,   32'h0,        4'h0,    0)); // 9 idle
    vq.push_back(mk(0, 1, 0, 32'h300,      32'h0,        4'hF,    0, 6'h00, 0, 32'h0,        1, 32'h0,        0, 0, 32'h0,   32'h0,        4'h0,    0)); // 10 load request
    vq.push_back(mk(0, 0, 0, 32'h0,        32'h0,        4'h0,    0, 6'h03, 1, 32'hCAFEF00D, 0, 32'hCAFEF00D, 1, 0, 32'h300, 32'h0,        4'hF,    0)); // 11 ack under stall
    vq.push_back(mk(0, 0, 0, 32'h0,        32'h0,        4'h0,    0, 6'h03, 0, 32'h0,        0, 32'hCAFEF00D, 0, 0, 32'h0,   32'h0,        4'h0,    0)); // 12 hold 1
    vq.push_back(mk(0, 1, 0, 32'h3FC,      32'h0,        4'hF,    0, 6'h03, 1, 32'h55555555, 0, 32'hCAFEF00D, 0, 0, 32'h0,   32'h0,        4'h0,    0)); // 13 hold 2, ce/ack ignored
    vq.push_back(mk(0, 0, 0, 32'h0,        32'h0,        4'h0,    0, 6'h00, 0, 32'h0,        0, 32'hCAFEF00D, 0, 0, 32'h0,   32'h0,        4'h0,    0)); // 14 hold 3, stall released
    vq.push_back(mk(0, 0, 0, 32'h0,        32'h0,        4'h0,    0, 6'h00, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0,   32'h0,        4'h0,    0)); // 15 idle
    vq.push_back(mk(0, 1, 1, 32'h400,      32'hA5A5A5A5, 4'hF,    0, 6'h00, 0, 32'h0,        1, 32'h0,        0, 0, 32'h0,   32'h0,        4'h0,    0)); // 16 store request
    vq.push_back(mk(0, 0, 0, 32'h0,        32'h0,        4'h0,    0, 6'h00, 0, 32'h0,        1, 32'h0,        1, 1, 32'h400, 32'hA5A5A5A5, 4'hF,    0)); // 17 busy 1
    vq.push_back(mk(0, 0, 0, 32'h0,        32'h0,        4'h0,    1, 6'h00, 0, 32'h0,        0, 32'h0,        1, 1, 32'h400, 32'hA5A5A5A5, 4'hF,    0)); // 18 flush, no ack
    vq.push_back(mk(0, 0, 0, 32'h0,        32'h0,        4'h0,    0, 6'h00, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0,   32'h0,        4'h0,    0)); // 19 idle
    vq.push_back(mk(0, 1, 0, 32'h500,      32'h0,        4'hF,    0, 6'h00, 0, 32'h0,        1, 32'h0,        0, 0, 32'h0,   32'h0,        4'h0,    0)); // 20 load request
    vq.push_back(mk(0, 0, 0, 32'h0,        32'h0,        4'h0,    0, 6'h00, 0, 32'h0,        1, 32'h0,        1, 0, 32'h500, 32'h0,        4'hF,    0)); // 21 busy 1
    vq.push_back(mk(0, 0, 0, 32'h0,        32'h0,        4'h0,    1, 6'h03, 1, 32'hBADC0FFE, 0, 32'h0,        1, 0, 32'h500, 32'h0,        4'hF,    0)); // 22 flush with ack
    vq.push_back(mk(0, 0, 0, 32'h0,        32'h0,        4'h0,    0, 6'h03, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0,   32'h0,        4'h0,    0)); // 23 idle, not wait-stall
    vq.push_back(mk(0, 1, 0, 32'h600,      32'h0,        4'hF,    0, 6'h00, 0, 32'h0,        1, 32'h0,        0, 0, 32'h0,   32'h0,        4'h0,    0)); // 24 load request
    vq.push_back(mk(0, 0, 0, 32'h0,        32'h0,        4'h0,    0, 6'h00, 0, 32'h0,        1, 32'h0,        1, 0, 32'h600, 32'h0,        4'hF,    0)); // 25 no ack 1
    vq.push_back(mk(0, 0, 0, 32'h0,        32'h0,        4'h0,    0, 6'h00, 0, 32'h0,        1, 32'h0,        1, 0, 32'h600, 32'h0,        4'hF,    0)); // 26 no ack 2
    vq.push_back(mk(0, 0, 0, 32'h0,        32'h0,        4'h0,    0, 6'h00, 0, 32'h0,        1, 32'h0,        1, 0, 32'h600, 32'h0,        4'hF,    0)); // 27 no ack 3
    vq.push_back(mk(0, 0, 0, 32'h0,        32'h0,        4'h0,    0, 6'h00, 0, 32'h0,        1, 32'h0,        1, 0, 32'h600, 32'h0,        4'hF,    0)); // 28 no ack 4, abort
    vq.push_back(mk(0, 0, 0, 32'h0,        32'h0,        4'h0,    0, 6'h00, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0,   32'h0,        4'h0,    1)); // 29 bus_err pulse
    vq.push_back(mk(0, 1, 0, 32'h700,      32'h0,        4'hF,    0, 6'h00, 0, 32'h0,        1, 32'h0,        0, 0, 32'h0,   32'h0,        4'h0,    0)); // 30 next request
    vq.push_back(mk(0, 0, 0, 32'h0,        32'h0,        4'h0,    0, 6'h00, 1, 32'h0BADF00D, 0, 32'h0BADF00D, 1, 0, 32'h700, 32'h0,        4'hF,    0)); // 31 normal ack
    vq.push_back(mk(0, 0, 0, 32'h0,        32'h0,        4'h0,    0, 6'h00, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0,   32'h0,        4'h0,    0)); // 32 idle
    vq.push_back(mk(0, 1, 1, 32'h800,      32'h00000077, 4'b0011, 0, 6'h00, 0, 32'h0,        1, 32'h0,        0, 0, 32'h0,   32'h0,        4'h0,    0)); // 33 store request
    vq.push_back(mk(1, 0, 0, 32'h0,        32'h0,        4'h0,    0, 6'h00, 0, 32'h0,        1, 32'h0,        1, 1, 32'h800, 32'h00000077, 4'b0011, 0)); // 34 rst during busy
    vq.push_back(mk(0, 0, 0, 32'h0,        32'h0,        4'h0,    0, 6'h00, 1, 32'h00000099, 0, 32'h0,        0, 0, 32'h0,   32'h0,        4'h0,    0)); // 35 late ack ignored
    vq.push_back(mk(0, 0, 0, 32'h0,        32'h0,        4'h0,    0, 6'h00, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0,   32'h0,        4'h0,    0)); // 36 idle

    apply(vq[0]);
    repeat (2) @(posedge clk);

    for (int i = 0; i < vq.size(); i++) begin
      @(posedge clk);
      #1;
      apply(vq[i]);
      #2;
      check($sformatf("v%0d_stallreq", i), 32'(stallreq_o),   32'(vq[i].x_sreq));
      check($sformatf("v%0d_cpu_data", i), cpu_data_o,        vq[i].x_cd);
      check($sformatf("v%0d_cyc", i),      32'(bus.wb_cyc_o), 32'(vq[i].x_cyc));
      check($sformatf("v%0d_stb", i),      32'(bus.wb_stb_o), 32'(vq[i].x_cyc));
      check($sformatf("v%0d_we", i),       32'(bus.wb_we_o),  32'(vq[i].x_we));
      check($sformatf("v%0d_adr", i),      bus.wb_adr_o,      vq[i].x_adr);
      check($sformatf("v%0d_dat", i),      bus.wb_dat_o,      vq[i].x_dat);
      check($sformatf("v%0d_sel", i),      32'(bus.wb_sel_o), 32'(vq[i].x_sel));
      check($sformatf("v%0d_bus_err", i),  32'(bus_err_o),    32'(vq[i].x_err));
    end

    // Loads against a slave with 0, 1 and 2 wait states: stall length tracks latency.
    for (int w = 0; w < 3; w++) begin
      sreq_cycles = 0;
      @(posedge clk);
      #1;
      cpu_ce_i     = 1'b1;
      cpu_we_i     = 1'b0;
      cpu_addr_i   = 32'h1000 + 32'(w * 4);
      cpu_sel_i    = 4'hF;
      bus.wb_ack_i = 1'b0;
      #2;
      if (stallreq_o) sreq_cycles++;
      for (int k = 0; k <= w; k++) begin
        @(posedge clk);
        #1;
        cpu_ce_i     = 1'b0;
        bus.wb_ack_i = (k == w);
        bus.wb_dat_i = 32'hA0000000 | 32'(w);
        #2;
        if (stallreq_o) sreq_cycles++;
        check($sformatf("ws%0d_k%0d_adr", w, k), bus.wb_adr_o, 32'h1000 + 32'(w * 4));
        if (k == w) check($sformatf("ws%0d_rdata", w), cpu_data_o, 32'hA0000000 | 32'(w));
      end
      @(posedge clk);
      #1;
      bus.wb_ack_i = 1'b0;
      #2;
      check($sformatf("ws%0d_cyc_done", w), 32'(bus.wb_cyc_o), 32'd0);
      check($sformatf("ws%0d_stall_len", w), 32'(sreq_cycles), 32'(w + 1));
      check($sformatf("ws%0d_no_err", w), 32'(bus_err_o), 32'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
